key_expansion_seq: RTL and testbench
====================================

Name: key_expansion_seq

Overview:
- Sequential, run-time-configurable AES key expansion engine.
- Successor to the combinational fixed-Nk expander: one datapath covers AES-128/192/256, selected per job by `mode`.
- Generates one 32-bit schedule word per clock, so it needs only one SubWord unit (4 sBox instances).
- Holds the finished schedule for the cipher datapath. The schedule is readable in full, or one round key at a time.

Parameters:
- MAX_NK, 8, largest supported key length in words (4, 6 or 8). Sets the storage size to 4*(MAX_NK+7) words.
- KEY_W, 32*MAX_NK, width of the key input port.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new expansion; sampled only while idle.
- mode  input  2  0 = AES-128 (Nk 4, Nr 10); 1 = AES-192 (Nk 6, Nr 12); 2 = AES-256 (Nk 8, Nr 14); 3 = reserved.
- key  input  KEY_W  cipher key, left-justified. Bits [0:32*Nk-1] are used; the rest are ignored. Bit 0 is the MSB of word 0.
- busy  output  1  expansion in progress.
- done  output  1  one-cycle pulse when the last word has been written.
- valid  output  1  schedule complete and stable.
- err  output  1  one-cycle pulse when a start request is rejected.
- rk_idx  input  4  round-key index for the read port.
- round_key  output  128  words 4*rk_idx .. 4*rk_idx+3 (combinational); zero if rk_idx > Nr of the stored schedule or valid=0.
- keyschedule  output  32*4*(MAX_NK+7)  whole word array, word i at bits [32i +: 32]; unused tail words read zero.

Behaviour:
- Reset (async, any time, including mid-run):
  - busy, done, valid, err = 0.
  - Word array, index counter, Nk/Nr registers and rcon register cleared.
  - Returns to IDLE.
- States: IDLE, RUN.
- IDLE, start=1, mode legal (mode != 3 and Nk <= MAX_NK), on that edge:
  - Words 0..Nk-1 loaded from key; all other words cleared.
  - Nk and Nr latched.
  - idx = Nk, phase counter j = 0, rcon = 0x01.
  - valid = 0, busy = 1, go to RUN.
- IDLE, start=1, mode illegal: err pulses for 1 cycle; no other state changes; valid and the array keep their previous values.
- RUN, one edge per word, writing w[idx] from t = w[idx-1]:
  - j == 0: w[idx] = w[idx-Nk] ^ SubWord(RotWord(t)) ^ {rcon, 24'h0}. Then rcon = xtime(rcon): 0x80 becomes 0x1B, otherwise shift left by 1.
  - Nk == 8 and j == 4: w[idx] = w[idx-8] ^ SubWord(t).
  - Otherwise: w[idx] = w[idx-Nk] ^ t.
  - Then idx++, and j++ wrapping to 0 at Nk. No division or modulo hardware.
- Completion: on the edge that writes word 4*(Nr+1)-1:
  - busy = 0, done = 1 (for 1 cycle), valid = 1, go to IDLE.
- Latency: start edge to done high is 40 / 46 / 52 clocks for modes 0 / 1 / 2.
- start while RUN: ignored. No restart, no err.
- start on the cycle done is high: state is already IDLE, so it is accepted normally.
- mode and key: sampled only on the accepting edge; later changes have no effect.
- Last-word outputs: rcon reaches 0x36 (AES-128) and is never advanced past its final use. The last word of each mode is computed exactly; no extra words are written.

Test Plan:
- Mode 0, key 2b7e151628aed2a6abf7158809cf4f3c:
  - w4 = a0fafe17, w43 = b6630ca6.
  - done exactly 40 clocks after the start edge.
  - round_key with rk_idx=10 is d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rk_idx=11 reads zero.
- Mode 1, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - w6 = fe0c91f7, w51 = 01002202.
  - done after 46 clocks; words 52..59 read zero.
- Mode 2, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - w8 = 9ba35411, w12 = a8b09c1a (the j==4 SubWord path), w59 = 706c631e.
  - done after 52 clocks.
- Control and handshake:
  - mode=3 with start → err pulses 1 cycle, busy stays 0, the previous valid schedule is unchanged.
  - Second start at cycle 10 of a run → ignored; the result still matches the first key.
- Reset during RUN:
  - Assert rst at cycle 20 of a mode-0 run → outputs 0 immediately (asynchronous), keyschedule all zero.
  - After release, a fresh mode-2 run produces the correct vectors.
- Back-to-back jobs:
  - Mode 0 then mode 1, second start on the done cycle → second job accepted.
  - Result is w51 = 01002202, with no stale words beyond word 51.

Source files
------------

// File: rtl/key_expansion_seq_if.sv
// rtl/key_expansion_seq_if.sv - request/status/read bundle of the sequential AES key expander
interface key_expansion_seq_if #(
  parameter int MAX_NK = 8,
  parameter int KEY_W  = 32 * MAX_NK
);
  localparam int NW = 4 * (MAX_NK + 7);

  logic             start_i;
  logic [1:0]       mode_i;
  logic [0:KEY_W-1] key_i;
  logic [3:0]       rk_idx_i;
  logic             busy_o;
  logic             done_o;
  logic             valid_o;
  logic             err_o;
  logic [127:0]     round_key_o;
  logic [32*NW-1:0] keyschedule_o;

  modport slave (
    input  start_i, mode_i, key_i, rk_idx_i,
    output busy_o, done_o, valid_o, err_o, round_key_o, keyschedule_o
  );

  modport master (
    output start_i, mode_i, key_i, rk_idx_i,
    input  busy_o, done_o, valid_o, err_o, round_key_o, keyschedule_o
  );
endinterface

// File: rtl/key_expansion_seq.sv
// rtl/key_expansion_seq.sv - one-word-per-clock AES-128/192/256 key schedule generator with schedule store
module key_expansion_seq #(
  parameter int MAX_NK = 8,
  parameter int KEY_W  = 32 * MAX_NK
) (
  input  logic               clk,
  input  logic               rst,
  key_expansion_seq_if.slave bus
);
  localparam int NW = 4 * (MAX_NK + 7);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // Inverse as x^254 (zero maps to zero), followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [0:0]  state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [2:0]  j_q, j_d;
  logic [3:0]  nk_q, nk_d;
  logic [3:0]  nr_q, nr_d;
  logic [7:0]  rcon_q, rcon_d;
  logic        done_q, done_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [31:0] w_q [NW];
  logic [31:0] w_d [NW];

  logic [31:0] t_word, k_word, sub_in, sub_out, new_word;
  logic [5:0]  last_idx;
  logic [3:0]  req_nk;
  logic        mode_ok, j_wrap, rcon_more;

  assign last_idx  = {nr_q, 2'b00} + 6'd3;
  assign t_word    = w_q[idx_q - 6'd1];
  assign k_word    = w_q[idx_q - {2'b00, nk_q}];
  assign sub_in    = (j_q == 3'd0) ? {t_word[23:0], t_word[31:24]} : t_word;
  assign sub_out   = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
  assign req_nk    = 4'd4 + {1'b0, bus.mode_i, 1'b0};
  assign mode_ok   = (bus.mode_i != 2'd3) && (req_nk <= 4'(MAX_NK));
  assign j_wrap    = (({1'b0, j_q} + 4'd1) == nk_q);
  // rcon only advances if another j==0 word still lies ahead in this job.
  assign rcon_more = (({1'b0, idx_q} + {3'b000, nk_q}) <= {1'b0, last_idx});

  always_comb begin
    new_word = k_word ^ t_word;
    if (j_q == 3'd0)
      new_word = k_word ^ sub_out ^ {rcon_q, 24'h000000};
    else if (nk_q == 4'd8 && j_q == 3'd4)
      new_word = k_word ^ sub_out;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    j_d     = j_q;
    nk_d    = nk_q;
    nr_d    = nr_q;
    rcon_d  = rcon_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    for (int i = 0; i < NW; i++) w_d[i] = w_q[i];
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (mode_ok) begin
            for (int i = 0; i < NW; i++) w_d[i] = '0;
            for (int i = 0; i < KEY_W / 32; i++)
              if (i < int'(req_nk)) w_d[i] = bus.key_i[32*i +: 32];
            nk_d    = req_nk;
            nr_d    = req_nk + 4'd6;
            idx_d   = {2'b00, req_nk};
            j_d     = 3'd0;
            rcon_d  = 8'h01;
            valid_d = 1'b0;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        w_d[idx_q] = new_word;
        idx_d      = idx_q + 6'd1;
        j_d        = j_wrap ? 3'd0 : j_q + 3'd1;
        if (j_q == 3'd0 && rcon_more)
          rcon_d = rcon_q[7] ? 8'h1b : {rcon_q[6:0], 1'b0};
        if (idx_q == last_idx) begin
          state_d = IDLE;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      j_q     <= '0;
      nk_q    <= '0;
      nr_q    <= '0;
      rcon_q  <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NW; i++) w_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      j_q     <= j_d;
      nk_q    <= nk_d;
      nr_q    <= nr_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      for (int i = 0; i < NW; i++) w_q[i] <= w_d[i];
    end
  end

  assign bus.busy_o  = (state_q == RUN);
  assign bus.done_o  = done_q;
  assign bus.valid_o = valid_q;
  assign bus.err_o   = err_q;

  always_comb begin
    bus.round_key_o = '0;
    if (valid_q && bus.rk_idx_i <= nr_q)
      bus.round_key_o = {w_q[{bus.rk_idx_i, 2'b00}], w_q[{bus.rk_idx_i, 2'b01}],
                         w_q[{bus.rk_idx_i, 2'b10}], w_q[{bus.rk_idx_i, 2'b11}]};
  end

  always_comb begin
    bus.keyschedule_o = '0;
    for (int i = 0; i < NW; i++) bus.keyschedule_o[32*i +: 32] = w_q[i];
  end
endmodule

// File: tb/tb_key_expansion_seq.sv
// tb/tb_key_expansion_seq.sv - scoreboard bench for key_expansion_seq against a FIPS-197 style reference model
module tb_key_expansion_seq;
  localparam int NW = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  key_expansion_seq_if #(.MAX_NK(8)) bus ();
  key_expansion_seq #(.MAX_NK(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [32*NW-1:0] ks;
    int               acc;
    int               lat;
  } exp_t;
  exp_t sb_q[$];
  logic [32*NW-1:0] last_ks;

  logic [0:2047] sbox_tab = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [31:0] subw(input logic [31:0] x);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = sbox_tab[8*int'(x[8*b +: 8]) +: 8];
    return r;
  endfunction

  function automatic logic [32*NW-1:0] model(input int m, input logic [255:0] k);
    logic [31:0]      w [NW];
    logic [79:0]      rcv;
    logic [32*NW-1:0] r;
    logic [31:0]      t;
    int               nk, nr;
    rcv = 80'h01020408102040801b36;
    nk  = 4 + 2 * m;
    nr  = nk + 6;
    for (int i = 0; i < NW; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0)
        t = subw({t[23:0], t[31:24]}) ^ {rcv[79 - 8*(i/nk - 1) -: 8], 24'h0};
      else if (nk > 6 && i % nk == 4)
        t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < NW; i++) r[32*i +: 32] = w[i];
    return r;
  endfunction

  function automatic int lat_of(input int m);
    case (m)
      0:       return 40;
      1:       return 46;
      default: return 52;
    endcase
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [31:0] wd(input int i);
    return bus.keyschedule_o[32*i +: 32];
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic check_ks(input string name, input logic [32*NW-1:0] got, input logic [32*NW-1:0] exp);
    int bad;
    bad = -1;
    checks++;
    for (int i = NW - 1; i >= 0; i--)
      if (got[32*i +: 32] !== exp[32*i +: 32]) bad = i;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: word %0d got %h required %h", name, bad, got[32*bad +: 32], exp[32*bad +: 32]);
    end
  endtask

  // Called just before an active edge; that edge samples the request.
  task automatic issue(input int m, input logic [255:0] k, input bit accept);
    exp_t  e;
    logic [255:0] junk;
    bus.start_i = 1'b1;
    bus.mode_i  = 2'(m);
    bus.key_i   = k;
    if (accept) begin
      e.ks    = model(m, k);
      e.acc   = cyc + 1;
      e.lat   = lat_of(m);
      last_ks = e.ks;
      sb_q.push_back(e);
    end
    @(negedge clk);
    junk        = rand256();
    bus.start_i = 1'b0;
    bus.mode_i  = 2'($urandom_range(0, 3));
    bus.key_i   = junk;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (bus.done_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.done_o !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within 100 cycles, required done");
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done_o === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done with empty scoreboard, required no done");
        end else begin
          e = sb_q.pop_front();
          check_ks("schedule", bus.keyschedule_o, e.ks);
          check("latency", 128'(cyc - e.acc), 128'(e.lat));
          check("valid_at_done", 128'(bus.valid_o), 128'(1));
          check("busy_at_done", 128'(bus.busy_o), 128'(0));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [255:0]     k128, k192, k256, junk, k;
    logic [32*NW-1:0] saved;
    logic [127:0]     exp_rk;
    int               m, rk, nr;
    bit               b2b;

    bus.start_i  = 1'b0;
    bus.mode_i   = 2'd0;
    bus.key_i    = '0;
    bus.rk_idx_i = 4'd0;

    junk = rand256();
    k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, junk[127:0]};
    k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, junk[63:0]};
    k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    repeat (3) @(negedge clk);
    check("rst_busy", 128'(bus.busy_o), 128'(0));
    check("rst_valid", 128'(bus.valid_o), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    check("idle_done", 128'(bus.done_o), 128'(0));
    check("idle_err", 128'(bus.err_o), 128'(0));
    check_ks("rst_schedule", bus.keyschedule_o, '0);
    check("rst_round_key", bus.round_key_o, 128'(0));

    // AES-128 vector
    issue(0, k128, 1'b1);
    wait_done();
    check("m0_w4", 128'(wd(4)), 128'(32'ha0fafe17));
    check("m0_w43", 128'(wd(43)), 128'(32'hb6630ca6));
    bus.rk_idx_i = 4'd10;
    #1 check("m0_rk10", bus.round_key_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    bus.rk_idx_i = 4'd11;
    #1 check("m0_rk11_zero", bus.round_key_o, 128'(0));
    bus.rk_idx_i = 4'd0;
    @(negedge clk);

    // reserved mode is rejected and leaves the stored schedule alone
    saved = bus.keyschedule_o;
    issue(3, rand256(), 1'b0);
    check("err_pulse", 128'(bus.err_o), 128'(1));
    check("err_busy", 128'(bus.busy_o), 128'(0));
    check("err_valid_kept", 128'(bus.valid_o), 128'(1));
    check_ks("err_schedule_kept", bus.keyschedule_o, saved);
    @(negedge clk);
    check("err_one_cycle", 128'(bus.err_o), 128'(0));

    // AES-192 vector
    issue(1, k192, 1'b1);
    wait_done();
    check("m1_w6", 128'(wd(6)), 128'(32'hfe0c91f7));
    check("m1_w51", 128'(wd(51)), 128'(32'h01002202));
    check("m1_tail_zero", bus.keyschedule_o[32*NW-1 -: 256], 128'(0));
    @(negedge clk);

    // AES-256 vector with an ignored second start mid-run
    issue(2, k256, 1'b1);
    repeat (8) @(negedge clk);
    check("run_round_key_zero", bus.round_key_o, 128'(0));
    issue(0, rand256(), 1'b0);
    check("restart_ignored_busy", 128'(bus.busy_o), 128'(1));
    check("restart_no_err", 128'(bus.err_o), 128'(0));
    wait_done();
    check("m2_w8", 128'(wd(8)), 128'(32'h9ba35411));
    check("m2_w12", 128'(wd(12)), 128'(32'ha8b09c1a));
    check("m2_w59", 128'(wd(59)), 128'(32'h706c631e));
    @(negedge clk);

    // asynchronous reset in the middle of a run
    issue(0, rand256(), 1'b1);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_busy", 128'(bus.busy_o), 128'(0));
    check("arst_valid", 128'(bus.valid_o), 128'(0));
    check_ks("arst_schedule", bus.keyschedule_o, '0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(2, k256, 1'b1);
    wait_done();
    check("post_rst_w12", 128'(wd(12)), 128'(32'ha8b09c1a));
    check("post_rst_w59", 128'(wd(59)), 128'(32'h706c631e));
    @(negedge clk);

    // back-to-back: second start while done is high
    issue(0, rand256(), 1'b1);
    wait_done();
    issue(1, k192, 1'b1);
    wait_done();
    check("b2b_w51", 128'(wd(51)), 128'(32'h01002202));
    check("b2b_tail_zero", bus.keyschedule_o[32*NW-1 -: 256], 128'(0));
    @(negedge clk);

    // randomized jobs with round-key reads
    for (int n = 0; n < 10; n++) begin
      m = $urandom_range(0, 2);
      k = rand256();
      issue(m, k, 1'b1);
      wait_done();
      nr = 10 + 2 * m;
      for (int r = 0; r < 3; r++) begin
        rk = $urandom_range(0, 15);
        bus.rk_idx_i = 4'(rk);
        exp_rk = '0;
        if (rk <= nr)
          exp_rk = {last_ks[32*(4*rk) +: 32], last_ks[32*(4*rk+1) +: 32],
                    last_ks[32*(4*rk+2) +: 32], last_ks[32*(4*rk+3) +: 32]};
        #1 check("rand_round_key", bus.round_key_o, exp_rk);
      end
      b2b = ($urandom_range(0, 1) == 1);
      if (!b2b) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 128'(sb_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
